sram_arb_2p: RTL and testbench
==============================

Name: sram_arb_2p

Overview:
- Two-port arbiter that shares one sky130_sram_2kbyte_1rw1r_32x512_8 RW port (port 0) between two requesters: p0 = core instruction fetch, p1 = core load/store.
- Uses a req/gnt/rvalid handshake: gnt is combinational in the request cycle, and rvalid follows one cycle later.
- Drives the macro's csb0/web0/wmask0/addr0/din0 and returns dout0 to the owning requester.
- Sits between the core memory ports and the SRAM macro, replacing direct macro instantiation.

Parameters:
- RAM_SIZE, 2048: macro capacity in bytes.
- ADDR_WIDTH, 32: requester byte-address width.
- BASE_ADDR, 32'h0000_0000: byte address mapped to RAM word 0.

Ports:
- clk  in  1  system clock; also clocks the macro.
- rst_i  in  1  synchronous reset, active-high.
- p0_req_i / p1_req_i  in  1  request; must stay high with stable addr/we/be/wdata until gnt.
- p0_gnt_o / p1_gnt_o  out  1  request accepted this cycle.
- p0_addr_i / p1_addr_i  in  ADDR_WIDTH  byte address.
- p0_we_i / p1_we_i  in  1  1 = write, 0 = read.
- p0_be_i / p1_be_i  in  4  byte enables.
- p0_wdata_i / p1_wdata_i  in  32  write data.
- p0_rvalid_o / p1_rvalid_o  out  1  response for the previous cycle's grant.
- p0_rdata_o / p1_rdata_o  out  32  read data; valid with rvalid.
- p0_err_o / p1_err_o  out  1  error response; see Optional Feature.
- bypass_en_i  in  1  1 = suppress all RAM writes; the requester still sees the handshake.
- ram_csb_o  out  1  macro chip select, active-low.
- ram_web_o  out  1  macro write enable, active-low.
- ram_wmask_o  out  4  macro write mask.
- ram_addr_o  out  9  macro word address.
- ram_din_o  out  32  macro write data.
- ram_dout_i  in  32  macro read data; valid the cycle after csb low.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst_i is synchronous and active-high.
- State:
  - rr_ptr (1 bit): 0 means p0 has priority.
  - rv0, rv1: response-pending flags.
  - rd_q: the pending response is a read.
  - err_q: error flag (present only with the macro).
- Reset values:
  - rr_ptr = 0; rv0 = rv1 = 0; rd_q = 0; err_q = 0.
  - While rst_i = 1: gnt outputs 0, ram_csb_o = 1, ram_web_o = 1, rvalid outputs 0, rdata outputs 0, err outputs 0.
- Arbitration (combinational, at most one grant per cycle):
  - Only one req high: that port is granted.
  - Both req high: the port selected by rr_ptr is granted.
  - Neither req high: no grant; ram_csb_o = 1.
- Priority update:
  - On any grant, rr_ptr <= index of the non-granted port.
  - A solo requester is therefore never starved.
  - With both ports requesting every cycle, grants alternate p0, p1, p0, ...
- Macro drive in a granted cycle:
  - ram_csb_o = 0.
  - ram_web_o = ~(we & ~bypass_en_i).
  - ram_wmask_o = be.
  - ram_addr_o = (addr − BASE_ADDR)[10:2].
  - ram_din_o = wdata.
- Macro drive in an idle cycle:
  - ram_web_o = 1; ram_wmask_o = 0.
  - ram_addr_o and ram_din_o hold their last values; no toggling is required.
- Response (latency 1):
  - On the edge after a grant, rvN <= 1 for the granted port only and rd_q <= ~we.
  - Cycle after the grant: pN_rvalid_o = rvN.
  - pN_rdata_o = ram_dout_i when rvN & rd_q, else 0.
  - Writes also produce exactly one rvalid pulse, with rdata = 0.
- Throughput:
  - A new grant is allowed every cycle.
  - The response for grant k coincides with the request/grant cycle for k+1.
- bypass_en_i:
  - A write while bypass_en_i = 1 is granted and acknowledged with rvalid, but the RAM content is unchanged.
  - Reads are unaffected.
- Boundary conditions:
  - be = 0 on a write: granted and acknowledged; no bytes change.
  - Request deasserted before gnt: legal; no response is generated.
  - rst_i asserted during a pending response: the response is dropped (rv cleared); no rvalid after reset.
  - Address aliasing (no macro): any address maps modulo RAM_SIZE.
  - Both ports targeting the same word in consecutive cycles: responses are strictly in grant order. A p1 write followed by a p0 read of the same word returns the new data.

Optional Feature:
- Macro name: SRAM_ARB_ERR_EN.
- Defined:
  - A request with (addr − BASE_ADDR) ≥ RAM_SIZE (unsigned) is granted normally by the arbiter.
  - ram_csb_o stays 1 and ram_web_o stays 1, so the macro is not accessed.
  - Next cycle: rvalid = 1, err = 1, rdata = 0 on the owning port.
  - In-range responses have err = 0.
  - rr_ptr updates as for any grant.
- Not defined:
  - No range check; addresses alias modulo RAM_SIZE.
  - p0_err_o and p1_err_o are tied to 0; err_q is not implemented.

Test Plan:
- Reset/idle: hold rst_i = 1 for 3 cycles with both req high → gnt = 0, csb = 1, rvalid = 0 throughout. After release, p0 is granted first.
- Single read: p1 writes 32'hDEADBEEF to 0x40 with be = 4'hF, then p1 reads 0x40 → ram_addr_o = 9'd16 on both accesses. Read rvalid arrives 1 cycle after gnt with rdata = 32'hDEADBEEF.
- Contention: p0 and p1 request continuously for 6 cycles → grants p0, p1, p0, p1, p0, p1. Each rvalid lands on the correct port 1 cycle after its grant.
- Byte write and bypass:
  - Write 32'h11223344 with be = 4'b0010 to a word holding 0 → read returns 32'h00003300.
  - Repeat with bypass_en_i = 1 and data 32'hFFFFFFFF → write is acknowledged, read still returns 32'h00003300.
- Reset mid-transaction: grant a p0 read, assert rst_i on the next edge → p0_rvalid_o never pulses; rr_ptr = 0 afterwards.
- Out-of-range access:
  - With SRAM_ARB_ERR_EN: p1 reads 0x800 → gnt = 1, csb stays 1, next cycle rvalid = 1, err = 1, rdata = 0.
  - Without SRAM_ARB_ERR_EN: the same read returns the data at word 0, with err = 0.

Source files
------------

// File: rtl/sram_arb_2p.sv
// sram_arb_2p: round-robin arbiter sharing one SRAM RW port between fetch (p0) and load/store (p1); SRAM_ARB_ERR_EN adds an out-of-range error response
module sram_arb_2p #(
    parameter int unsigned            RAM_SIZE   = 2048,
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  p0_req_i,
    output logic                  p0_gnt_o,
    input  logic [ADDR_WIDTH-1:0] p0_addr_i,
    input  logic                  p0_we_i,
    input  logic [3:0]            p0_be_i,
    input  logic [31:0]           p0_wdata_i,
    output logic                  p0_rvalid_o,
    output logic [31:0]           p0_rdata_o,
    output logic                  p0_err_o,
    input  logic                  p1_req_i,
    output logic                  p1_gnt_o,
    input  logic [ADDR_WIDTH-1:0] p1_addr_i,
    input  logic                  p1_we_i,
    input  logic [3:0]            p1_be_i,
    input  logic [31:0]           p1_wdata_i,
    output logic                  p1_rvalid_o,
    output logic [31:0]           p1_rdata_o,
    output logic                  p1_err_o,
    input  logic                  bypass_en_i,
    output logic                  ram_csb_o,
    output logic                  ram_web_o,
    output logic [3:0]            ram_wmask_o,
    output logic [8:0]            ram_addr_o,
    output logic [31:0]           ram_din_o,
    input  logic [31:0]           ram_dout_i
);
    logic                  rr_ptr, rv0, rv1, rd_q;
    logic                  gnt, sel, we, oor, hit, resp_err;
    logic [ADDR_WIDTH-1:0] off;
    logic [8:0]            addr_q;
    logic [31:0]           din_q;
    logic                  unused;

    always_comb begin
        p0_gnt_o = ~rst_i & p0_req_i & (~p1_req_i | ~rr_ptr);
        p1_gnt_o = ~rst_i & p1_req_i & (~p0_req_i | rr_ptr);
    end

    assign gnt = p0_gnt_o | p1_gnt_o;
    assign sel = p1_gnt_o;
    assign we  = sel ? p1_we_i : p0_we_i;
    assign off = (sel ? p1_addr_i : p0_addr_i) - BASE_ADDR;

`ifdef SRAM_ARB_ERR_EN
    logic err_q;
    assign oor      = off >= ADDR_WIDTH'(RAM_SIZE);
    assign resp_err = err_q;
`else
    assign oor      = 1'b0;
    assign resp_err = 1'b0;
`endif

    // out-of-range grants still complete the handshake but never touch the macro
    assign hit = gnt & ~oor;

    always_comb begin
        ram_csb_o   = ~hit;
        ram_web_o   = ~(hit & we & ~bypass_en_i);
        ram_wmask_o = gnt ? (sel ? p1_be_i : p0_be_i) : 4'h0;
        ram_addr_o  = gnt ? off[10:2] : addr_q;
        ram_din_o   = gnt ? (sel ? p1_wdata_i : p0_wdata_i) : din_q;
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            rr_ptr <= 1'b0;
            rv0    <= 1'b0;
            rv1    <= 1'b0;
            rd_q   <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
        end else begin
            rv0 <= p0_gnt_o;
            rv1 <= p1_gnt_o;
            if (gnt) begin
                rr_ptr <= p0_gnt_o;
                rd_q   <= ~we;
                addr_q <= ram_addr_o;
                din_q  <= ram_din_o;
            end
        end
    end

`ifdef SRAM_ARB_ERR_EN
    always_ff @(posedge clk) begin
        if (rst_i)
            err_q <= 1'b0;
        else if (gnt)
            err_q <= oor;
    end
`endif

    always_comb begin
        p0_rvalid_o = ~rst_i & rv0;
        p1_rvalid_o = ~rst_i & rv1;
        p0_err_o    = ~rst_i & rv0 & resp_err;
        p1_err_o    = ~rst_i & rv1 & resp_err;
        p0_rdata_o  = (~rst_i & rv0 & rd_q & ~resp_err) ? ram_dout_i : 32'h0;
        p1_rdata_o  = (~rst_i & rv1 & rd_q & ~resp_err) ? ram_dout_i : 32'h0;
    end

    assign unused = ^{off[ADDR_WIDTH-1:11], off[1:0]};
endmodule

// File: tb/tb_sram_arb_2p.sv
// tb_sram_arb_2p: randomized scoreboard bench for sram_arb_2p against a word-array reference model
module tb_sram_arb_2p;
    localparam int RAM_SIZE = 2048;

    typedef struct {
        int          cyc;
        int          port;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req[2], we[2];
    logic [31:0] addr[2], wdata[2];
    logic [3:0]  be[2];
    logic        bypass = 1'b0;
    logic        gnt0, gnt1, rv0, rv1, err0, err1;
    logic [31:0] rd0, rd1;
    logic        ram_csb, ram_web;
    logic [3:0]  ram_wmask;
    logic [8:0]  ram_addr;
    logic [31:0] ram_din, ram_dout;

    logic [31:0] sram[512];
    logic [31:0] ref_mem[512];
    resp_t       q[$];
    int          cyc = 0, tests = 0, fails = 0, prio = 0;
    logic        gnt_seen[2];
    logic [31:0] last_rdata[2];
    logic        last_err[2];

    always #5 clk = ~clk;

    sram_arb_2p dut (
        .clk(clk), .rst_i(rst),
        .p0_req_i(req[0]), .p0_gnt_o(gnt0), .p0_addr_i(addr[0]), .p0_we_i(we[0]),
        .p0_be_i(be[0]), .p0_wdata_i(wdata[0]), .p0_rvalid_o(rv0), .p0_rdata_o(rd0), .p0_err_o(err0),
        .p1_req_i(req[1]), .p1_gnt_o(gnt1), .p1_addr_i(addr[1]), .p1_we_i(we[1]),
        .p1_be_i(be[1]), .p1_wdata_i(wdata[1]), .p1_rvalid_o(rv1), .p1_rdata_o(rd1), .p1_err_o(err1),
        .bypass_en_i(bypass),
        .ram_csb_o(ram_csb), .ram_web_o(ram_web), .ram_wmask_o(ram_wmask),
        .ram_addr_o(ram_addr), .ram_din_o(ram_din), .ram_dout_i(ram_dout)
    );

    // behavioural stand-in for the 1RW macro port
    always @(posedge clk) begin
        if (!ram_csb) begin
            if (!ram_web) begin
                for (int b = 0; b < 4; b++)
                    if (ram_wmask[b]) sram[ram_addr][8*b +: 8] = ram_din[8*b +: 8];
            end else begin
                ram_dout <= sram[ram_addr];
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model: arbitration rule, macro drive and expected responses
    always @(negedge clk) begin : model
        int          g;
        logic [31:0] off;
        logic        oor;
        logic [8:0]  idx;
        if (rst) begin
            q.delete();
            prio = 0;
            gnt_seen[0] = 1'b0;
            gnt_seen[1] = 1'b0;
            chk("rst_gnt", {gnt1, gnt0}, 0);
            chk("rst_csb_web", {ram_csb, ram_web}, 2'b11);
        end else begin
            g = (req[0] && req[1]) ? prio : req[0] ? 0 : req[1] ? 1 : -1;
            chk("gnt", {gnt1, gnt0}, {g == 1, g == 0});
            if (g >= 0) begin
                off = addr[g];
`ifdef SRAM_ARB_ERR_EN
                oor = off >= RAM_SIZE;
`else
                oor = 1'b0;
`endif
                idx = 9'((off % RAM_SIZE) / 4);
                chk("csb", ram_csb, oor);
                chk("web", ram_web, !(!oor && we[g] && !bypass));
                chk("wmask", ram_wmask, be[g]);
                if (!oor) chk("ram_addr", ram_addr, idx);
                if (!oor && we[g]) chk("ram_din", ram_din, wdata[g]);
                if (oor) begin
                    q.push_back('{cyc, g, 32'h0, 1'b1});
                end else if (we[g]) begin
                    if (!bypass)
                        for (int b = 0; b < 4; b++)
                            if (be[g][b]) ref_mem[idx][8*b +: 8] = wdata[g][8*b +: 8];
                    q.push_back('{cyc, g, 32'h0, 1'b0});
                end else begin
                    q.push_back('{cyc, g, ref_mem[idx], 1'b0});
                end
                prio = 1 - g;
            end else begin
                chk("idle_drive", {ram_csb, ram_web, ram_wmask}, 6'b110000);
            end
            gnt_seen[0] = (g == 0);
            gnt_seen[1] = (g == 1);
        end
    end

    // monitor: every response must land one cycle after its grant, in grant order
    always @(negedge clk) begin : monitor
        logic  e0, e1;
        resp_t r;
        if (rst) begin
            chk("rst_rvalid_err", {rv1, rv0, err1, err0}, 0);
            chk("rst_rdata", rd0 | rd1, 0);
        end else begin
            e0 = q.size() > 0 && q[0].cyc == cyc - 1 && q[0].port == 0;
            e1 = q.size() > 0 && q[0].cyc == cyc - 1 && q[0].port == 1;
            chk("rvalid", {rv1, rv0}, {e1, e0});
            if (e0 || e1) begin
                r = q.pop_front();
                chk("rdata", r.port == 1 ? rd1 : rd0, r.rdata);
                chk("err", r.port == 1 ? err1 : err0, r.err);
                last_rdata[r.port] = r.port == 1 ? rd1 : rd0;
                last_err[r.port]   = r.port == 1 ? err1 : err0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_req(input int p, input logic [31:0] a, input logic w, input logic [3:0] b,
                          input logic [31:0] d);
        int n = 0;
        req[p] = 1'b1; addr[p] = a; we[p] = w; be[p] = b; wdata[p] = d;
        do begin
            tick(1);
            n++;
        end while (!gnt_seen[p] && n < 20);
        chk("do_req_gnt", gnt_seen[p], 1);
        req[p] = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom_range(15) * 4 + $urandom_range(3);
        if ($urandom_range(3) == 0) a += $urandom_range(7, 1) * RAM_SIZE;
        return a;
    endfunction

    task automatic run_random(input int n, input int pct);
        for (int c = 0; c < n; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!req[p] || gnt_seen[p]) begin
                    req[p]   = $urandom_range(99) < pct;
                    addr[p]  = rand_addr();
                    we[p]    = 1'($urandom_range(1));
                    be[p]    = 4'($urandom_range(15));
                    wdata[p] = $urandom;
                end else if (pct < 100 && $urandom_range(7) == 0) begin
                    req[p] = 1'b0;
                end
            end
            bypass = $urandom_range(7) == 0;
            tick(1);
        end
        req[0] = 1'b0;
        req[1] = 1'b0;
        bypass = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            sram[i]    = 32'h0;
            ref_mem[i] = 32'h0;
        end
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b1; addr[p] = 32'h0; we[p] = 1'b0; be[p] = 4'hF; wdata[p] = 32'h0;
            gnt_seen[p] = 1'b0; last_rdata[p] = 32'h0; last_err[p] = 1'b0;
        end
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("first_gnt_p0", {gnt_seen[1], gnt_seen[0]}, 2'b01);
        req[0] = 1'b0;
        tick(1);
        chk("second_gnt_p1", gnt_seen[1], 1);
        req[1] = 1'b0;
        tick(2);

        do_req(1, 32'h40, 1'b1, 4'hF, 32'hDEADBEEF);
        do_req(1, 32'h40, 1'b0, 4'hF, 32'h0);
        tick(1);
        chk("read_deadbeef", last_rdata[1], 32'hDEADBEEF);

        run_random(6, 100);
        tick(2);

        do_req(0, 32'h80, 1'b1, 4'hF, 32'h0);
        do_req(0, 32'h80, 1'b1, 4'b0010, 32'h11223344);
        do_req(0, 32'h80, 1'b0, 4'hF, 32'h0);
        tick(1);
        chk("byte_write", last_rdata[0], 32'h00003300);
        bypass = 1'b1;
        do_req(1, 32'h80, 1'b1, 4'hF, 32'hFFFFFFFF);
        bypass = 1'b0;
        do_req(1, 32'h80, 1'b0, 4'hF, 32'h0);
        tick(1);
        chk("bypass_read", last_rdata[1], 32'h00003300);
        do_req(0, 32'h80, 1'b1, 4'h0, 32'hAAAAAAAA);
        do_req(0, 32'h80, 1'b0, 4'hF, 32'h0);
        tick(1);
        chk("be0_read", last_rdata[0], 32'h00003300);

        req[0] = 1'b1; addr[0] = 32'h80; we[0] = 1'b0;
        tick(1);
        chk("mid_rst_gnt", gnt_seen[0], 1);
        rst = 1'b1;
        req[0] = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(3);
        req[0] = 1'b1; req[1] = 1'b1; we[0] = 1'b0; we[1] = 1'b0;
        tick(1);
        chk("post_rst_p0_first", {gnt_seen[1], gnt_seen[0]}, 2'b01);
        req[0] = 1'b0;
        tick(1);
        req[1] = 1'b0;
        tick(2);

        do_req(0, 32'h0, 1'b1, 4'hF, 32'hCAFEF00D);
        do_req(1, 32'h800, 1'b0, 4'hF, 32'h0);
        tick(1);
`ifdef SRAM_ARB_ERR_EN
        chk("oor_err", last_err[1], 1);
        chk("oor_rdata", last_rdata[1], 32'h0);
`else
        chk("alias_err", last_err[1], 0);
        chk("alias_rdata", last_rdata[1], 32'hCAFEF00D);
`endif

        run_random(2000, 60);
        tick(5);
        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
